// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared memory-system constants and arbiter encodings
package mem_pkg;

  localparam int BLOCK_WIDTH = 128;
  localparam int OFFSET_BITS = 4;

  localparam logic [1:0] ARB_IDLE = 2'd0;
  localparam logic [1:0] ARB_I    = 2'd1;
  localparam logic [1:0] ARB_D    = 2'd2;

  // one-hot grant: bit 0 = icache, bit 1 = dcache
  localparam logic [1:0] GRANT_I = 2'b01;
  localparam logic [1:0] GRANT_D = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = ARB_IDLE,
    ST_I_XFER = ARB_I,
    ST_D_XFER = ARB_D
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - block-wide main-memory port shared by the caches
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH  = 32,
  parameter int BLOCK_WIDTH = mem_pkg::BLOCK_WIDTH
);

  logic                   mem_enable;
  logic                   mem_write;
  logic [ADDR_WIDTH-1:0]  mem_address;
  logic [BLOCK_WIDTH-1:0] mem_wdata;
  logic [BLOCK_WIDTH-1:0] mem_rdata;
  logic                   mem_valid;

  modport master (
    output mem_enable, mem_write, mem_address, mem_wdata,
    input  mem_rdata, mem_valid
  );

  modport slave (
    input  mem_enable, mem_write, mem_address, mem_wdata,
    output mem_rdata, mem_valid
  );

endinterface

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way round-robin grant, purely combinational
module rr_arbiter2
  import mem_pkg::*;
(
  input  logic       i_req,
  input  logic       d_req,
  input  logic       last_grant,
  output logic [1:0] grant
);

  // on a tie the requester that did not win last time goes first
  always_comb begin
    grant = 2'b00;
    if (i_req && d_req) begin
      grant = last_grant ? GRANT_I : GRANT_D;
    end else if (i_req) begin
      grant = GRANT_I;
    end else if (d_req) begin
      grant = GRANT_D;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares the main-memory port between icache refill and
// dcache refill/writeback with round-robin fairness
module mem_arbiter #(
  parameter int ADDR_WIDTH  = 32,
  parameter int BLOCK_WIDTH = mem_pkg::BLOCK_WIDTH,
  parameter int OFFSET_BITS = mem_pkg::OFFSET_BITS
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   i_req,
  input  logic [ADDR_WIDTH-1:0]  i_address,
  output logic [BLOCK_WIDTH-1:0] i_data,
  output logic                   i_done,
  input  logic                   d_req,
  input  logic                   d_write,
  input  logic [ADDR_WIDTH-1:0]  d_address,
  input  logic [BLOCK_WIDTH-1:0] d_wdata,
  output logic [BLOCK_WIDTH-1:0] d_data,
  output logic                   d_done,
  mem_arbiter_if.master          mem
);

  import mem_pkg::*;

  localparam logic [ADDR_WIDTH-1:0] OFFSET_MASK =
    ADDR_WIDTH'((64'd1 << OFFSET_BITS) - 64'd1);

  arb_state_t             state;
  arb_state_t             state_next;
  logic                   last_grant;
  logic [1:0]             grant;
  logic                   idle;
  logic [ADDR_WIDTH-1:0]  address_q;
  logic                   write_q;
  logic [BLOCK_WIDTH-1:0] wdata_q;
  logic [BLOCK_WIDTH-1:0] i_data_q;
  logic [BLOCK_WIDTH-1:0] d_data_q;

  rr_arbiter2 u_rr (
    .i_req      (i_req),
    .d_req      (d_req),
    .last_grant (last_grant),
    .grant      (grant)
  );

  assign idle = (state == ST_IDLE);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next     = state;
    i_done         = 1'b0;
    d_done         = 1'b0;
    mem.mem_enable = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (grant == GRANT_I) begin
          state_next = ST_I_XFER;
        end else if (grant == GRANT_D) begin
          state_next = ST_D_XFER;
        end
      end
      ST_I_XFER: begin
        mem.mem_enable = 1'b1;
        i_done         = mem.mem_valid;
        if (mem.mem_valid) state_next = ST_IDLE;
      end
      ST_D_XFER: begin
        mem.mem_enable = 1'b1;
        d_done         = mem.mem_valid;
        if (mem.mem_valid) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // transaction fields are captured only on the grant edge, so requester
  // changes during a transfer never reach the memory port
  always_ff @(posedge clock) begin
    if (!reset) begin
      last_grant <= 1'b1;
      address_q  <= '0;
      write_q    <= 1'b0;
      wdata_q    <= '0;
      i_data_q   <= '0;
      d_data_q   <= '0;
    end else begin
      if (idle && grant == GRANT_I) begin
        address_q  <= i_address & ~OFFSET_MASK;
        write_q    <= 1'b0;
        wdata_q    <= '0;
        last_grant <= 1'b0;
      end else if (idle && grant == GRANT_D) begin
        address_q  <= d_address & ~OFFSET_MASK;
        write_q    <= d_write;
        wdata_q    <= d_wdata;
        last_grant <= 1'b1;
      end
      if (i_done) i_data_q <= mem.mem_rdata;
      if (d_done && !write_q) d_data_q <= mem.mem_rdata;
    end
  end

  assign mem.mem_write   = write_q;
  assign mem.mem_address = address_q;
  assign mem.mem_wdata   = wdata_q;

  // read data is forwarded in the completion cycle and held afterwards
  assign i_data = i_done ? mem.mem_rdata : i_data_q;
  assign d_data = (d_done && !write_q) ? mem.mem_rdata : d_data_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized self-checking bench for mem_arbiter
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int BW = 128;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          i_req = 1'b0;
  logic [AW-1:0] i_address = '0;
  logic [BW-1:0] i_data;
  logic          i_done;
  logic          d_req = 1'b0;
  logic          d_write = 1'b0;
  logic [AW-1:0] d_address = '0;
  logic [BW-1:0] d_wdata = '0;
  logic [BW-1:0] d_data;
  logic          d_done;

  mem_arbiter_if #(.ADDR_WIDTH(AW), .BLOCK_WIDTH(BW)) mem_bus ();

  mem_arbiter #(.ADDR_WIDTH(AW), .BLOCK_WIDTH(BW), .OFFSET_BITS(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .i_req     (i_req),
    .i_address (i_address),
    .i_data    (i_data),
    .i_done    (i_done),
    .d_req     (d_req),
    .d_write   (d_write),
    .d_address (d_address),
    .d_wdata   (d_wdata),
    .d_data    (d_data),
    .d_done    (d_done),
    .mem       (mem_bus)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic timeout(input string name);
    checks++;
    $display("FAIL %s: timed out waiting for the DUT", name);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // memory model: answers each enabled transaction after a latency
  int            fixed_lat = 0;
  logic          fixed_data_en = 1'b0;
  logic [BW-1:0] fixed_data = '0;
  logic          stray = 1'b0;
  int            wait_cnt = 0;

  initial begin
    mem_bus.mem_valid = 1'b0;
    mem_bus.mem_rdata = '0;
    forever begin
      step();
      mem_bus.mem_valid = 1'b0;
      if (stray) begin
        mem_bus.mem_valid = 1'b1;
        mem_bus.mem_rdata = {$urandom, $urandom, $urandom, $urandom};
      end else if (mem_bus.mem_enable) begin
        if (wait_cnt == 0) wait_cnt = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 4));
        wait_cnt--;
        if (wait_cnt == 0) begin
          mem_bus.mem_valid = 1'b1;
          mem_bus.mem_rdata = fixed_data_en ? fixed_data : {$urandom, $urandom, $urandom, $urandom};
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // transaction-level reference: who owns the port and what was captured
  int            m_owner = 0;
  bit            m_next_i = 1'b1;
  logic [AW-1:0] m_addr = '0;
  logic          m_write = 1'b0;
  logic [BW-1:0] m_wdata = '0;
  logic [BW-1:0] m_idata = '0;
  logic [BW-1:0] m_ddata = '0;

  always @(posedge clock) begin
    if (!reset) begin
      m_owner  <= 0;
      m_next_i <= 1'b1;
      m_addr   <= '0;
      m_write  <= 1'b0;
      m_wdata  <= '0;
      m_idata  <= '0;
      m_ddata  <= '0;
    end else if (m_owner == 0) begin
      if (i_req && (!d_req || m_next_i)) begin
        m_owner  <= 1;
        m_addr   <= i_address & ~32'hF;
        m_write  <= 1'b0;
        m_wdata  <= '0;
        m_next_i <= 1'b0;
      end else if (d_req) begin
        m_owner  <= 2;
        m_addr   <= d_address & ~32'hF;
        m_write  <= d_write;
        m_wdata  <= d_wdata;
        m_next_i <= 1'b1;
      end
    end else if (mem_bus.mem_valid) begin
      if (m_owner == 1) m_idata <= mem_bus.mem_rdata;
      else if (!m_write) m_ddata <= mem_bus.mem_rdata;
      m_owner <= 0;
    end
  end

  always @(negedge clock) begin
    check("mem_enable", 128'(mem_bus.mem_enable), 128'(m_owner != 0));
    check("mem_write", 128'(mem_bus.mem_write), 128'(m_write));
    check("mem_address", 128'(mem_bus.mem_address), 128'(m_addr));
    check("mem_wdata", mem_bus.mem_wdata, m_wdata);
    check("i_done", 128'(i_done), 128'((m_owner == 1) && mem_bus.mem_valid));
    check("d_done", 128'(d_done), 128'((m_owner == 2) && mem_bus.mem_valid));
    check("i_data", i_data, ((m_owner == 1) && mem_bus.mem_valid) ? mem_bus.mem_rdata : m_idata);
    check("d_data", d_data,
          ((m_owner == 2) && mem_bus.mem_valid && !m_write) ? mem_bus.mem_rdata : m_ddata);
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded its time limit");
    $fatal(1, "global timeout");
  end

  logic [AW-1:0] exp_addr [4];
  int   grants, dones, gap, en_cycles, cnt_a, cnt_b, cnt_c;
  logic prev_en, seen, i_seen, d_seen;

  initial begin
    // reset held with both requests pending
    i_address = 32'h0000_0104;
    d_address = 32'h0000_0208;
    d_write   = 1'b0;
    i_req     = 1'b1;
    d_req     = 1'b1;
    repeat (3) begin
      @(negedge clock);
      check("reset_enable", 128'(mem_bus.mem_enable), 128'(0));
      check("reset_i_done", 128'(i_done), 128'(0));
      check("reset_d_done", 128'(d_done), 128'(0));
    end
    step();
    reset = 1'b1;

    // contention: grants alternate starting with the icache
    exp_addr = '{32'h100, 32'h200, 32'h100, 32'h200};
    grants = 0; dones = 0; gap = 0; prev_en = 1'b0;
    for (int cyc = 0; cyc < 200 && dones < 4; cyc++) begin
      @(negedge clock);
      if (mem_bus.mem_enable && !prev_en && grants < 4) begin
        check($sformatf("contention_addr%0d", grants), 128'(mem_bus.mem_address), 128'(exp_addr[grants]));
        if (grants > 0) check("contention_gap", 128'(gap), 128'(1));
        grants++;
      end
      if (mem_bus.mem_enable) gap = 0;
      else gap++;
      if (i_done || d_done) dones++;
      prev_en = mem_bus.mem_enable;
    end
    if (dones < 4) timeout("contention");
    step();
    i_req = 1'b0;
    d_req = 1'b0;
    step();

    // single icache refill, memory answers on the fourth enable cycle
    fixed_lat     = 4;
    fixed_data_en = 1'b1;
    fixed_data    = 128'hDEADBEEF_00000000_00000000_00000001;
    i_address     = 32'h0000_1234;
    i_req         = 1'b1;
    en_cycles = 0; seen = 1'b0;
    for (int cyc = 0; cyc < 50 && !seen; cyc++) begin
      @(negedge clock);
      if (mem_bus.mem_enable) begin
        en_cycles++;
        check("single_addr", 128'(mem_bus.mem_address), 128'(32'h0000_1230));
        check("single_write", 128'(mem_bus.mem_write), 128'(0));
      end
      check("single_no_d_done", 128'(d_done), 128'(0));
      if (i_done) begin
        seen = 1'b1;
        check("single_i_data", i_data, 128'hDEADBEEF_00000000_00000000_00000001);
      end
    end
    if (!seen) timeout("single_refill");
    check("single_latency", 128'(en_cycles), 128'(4));
    step();
    i_req = 1'b0;
    fixed_data_en = 1'b0;
    repeat (3) begin
      @(negedge clock);
      check("single_i_data_hold", i_data, 128'hDEADBEEF_00000000_00000000_00000001);
    end

    // dcache writeback
    fixed_lat = 2;
    d_write   = 1'b1;
    d_address = 32'h0000_2008;
    d_wdata   = {4{32'hA5A5_A5A5}};
    d_req     = 1'b1;
    cnt_a = 0; seen = 1'b0;
    for (int cyc = 0; cyc < 50 && !seen; cyc++) begin
      @(negedge clock);
      if (mem_bus.mem_enable) begin
        check("wb_addr", 128'(mem_bus.mem_address), 128'(32'h0000_2000));
        check("wb_write", 128'(mem_bus.mem_write), 128'(1));
        check("wb_wdata", mem_bus.mem_wdata, {4{32'hA5A5_A5A5}});
      end
      check("wb_no_i_done", 128'(i_done), 128'(0));
      if (d_done) begin
        seen = 1'b1;
        cnt_a++;
      end
    end
    if (!seen) timeout("writeback");
    step();
    d_req   = 1'b0;
    d_write = 1'b0;
    repeat (3) begin
      @(negedge clock);
      if (d_done) cnt_a++;
    end
    check("wb_done_count", 128'(cnt_a), 128'(1));

    // requester address changes during a transfer are ignored
    fixed_lat = 4;
    i_address = 32'h0000_0100;
    i_req     = 1'b1;
    seen = 1'b0;
    for (int cyc = 0; cyc < 50 && !seen; cyc++) begin
      @(negedge clock);
      if (mem_bus.mem_enable) begin
        check("hold_addr", 128'(mem_bus.mem_address), 128'(32'h0000_0100));
        i_address = 32'h0000_0200;
      end
      if (i_done) seen = 1'b1;
    end
    if (!seen) timeout("hold_addr");
    step();
    i_req = 1'b0;
    step();

    // reset mid-transaction, then a stray completion in IDLE
    fixed_lat = 8;
    d_write   = 1'b0;
    d_address = 32'h0000_0300;
    d_req     = 1'b1;
    seen = 1'b0;
    for (int cyc = 0; cyc < 20 && !seen; cyc++) begin
      @(negedge clock);
      if (mem_bus.mem_enable) seen = 1'b1;
    end
    if (!seen) timeout("midreset_grant");
    step();
    reset = 1'b0;
    d_req = 1'b0;
    step();
    reset = 1'b1;
    @(negedge clock);
    check("midreset_d_data", d_data, '0);
    stray = 1'b1;
    @(negedge clock);
    stray = 1'b0;
    cnt_a = 0; cnt_b = 0; cnt_c = 0;
    repeat (6) begin
      @(negedge clock);
      if (d_done) cnt_a++;
      if (i_done) cnt_b++;
      if (mem_bus.mem_enable) cnt_c++;
    end
    check("midreset_d_done", 128'(cnt_a), 128'(0));
    check("midreset_i_done", 128'(cnt_b), 128'(0));
    check("midreset_enable", 128'(cnt_c), 128'(0));

    // randomized traffic from both requesters
    fixed_lat = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge clock);
      i_seen = i_done;
      d_seen = d_done;
      step();
      if (i_req) begin
        if (i_seen) i_req = 1'b0;
        else if ($urandom_range(0, 3) == 0) i_address = $urandom;
      end else if ($urandom_range(0, 2) == 0) begin
        i_req     = 1'b1;
        i_address = $urandom;
      end
      if (d_req) begin
        if (d_seen) d_req = 1'b0;
        else if ($urandom_range(0, 3) == 0) d_address = $urandom;
      end else if ($urandom_range(0, 2) == 0) begin
        d_req     = 1'b1;
        d_write   = 1'($urandom_range(0, 1));
        d_address = $urandom;
        d_wdata   = {$urandom, $urandom, $urandom, $urandom};
      end
    end
    seen = 1'b0;
    for (int cyc = 0; cyc < 100 && !seen; cyc++) begin
      @(negedge clock);
      i_seen = i_done;
      d_seen = d_done;
      step();
      if (i_seen) i_req = 1'b0;
      if (d_seen) d_req = 1'b0;
      if (!i_req && !d_req) seen = 1'b1;
    end
    if (!seen) timeout("drain");
    repeat (3) @(negedge clock);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single 128-bit block-wide main-memory port between the instruction cache refill path and the data cache refill/writeback path.
- Arbitrates with round-robin fairness and latches the winner's address and data for the whole transaction.
- Drives the memory enable/write strobes and routes the memory completion pulse and read block back to the owning requester.
- Sits between both cache controllers and the memory model.

Parameters:
ADDR_WIDTH, 32, byte-address width
BLOCK_WIDTH, 128, cache block / memory transfer width in bits
OFFSET_BITS, 4, block-offset bits; forced to zero on the memory address

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-low reset
i_req  in  1  icache refill request, level, held until i_done
i_address  in  ADDR_WIDTH  icache miss address
i_data  out  BLOCK_WIDTH  refill block to icache
i_done  out  1  one-cycle completion pulse to icache
d_req  in  1  dcache request, level, held until d_done
d_write  in  1  1 = writeback, 0 = refill; stable while d_req is high
d_address  in  ADDR_WIDTH  dcache block address
d_wdata  in  BLOCK_WIDTH  dirty block for writeback
d_data  out  BLOCK_WIDTH  refill block to dcache
d_done  out  1  one-cycle completion pulse to dcache
mem_enable  out  1  memory transaction active
mem_write  out  1  memory write strobe
mem_address  out  ADDR_WIDTH  block-aligned address
mem_wdata  out  BLOCK_WIDTH  write block
mem_rdata  in  BLOCK_WIDTH  read block
mem_valid  in  1  one-cycle pulse: transaction complete, mem_rdata valid

Behaviour:
- States: IDLE, I_XFER, D_XFER. Registered state register `last_grant` (0 = icache, 1 = dcache).
- Reset (reset == 0 at a clock edge):
  - state = IDLE; last_grant = 1 (icache wins the first tie).
  - mem_enable = mem_write = 0, mem_address = 0, mem_wdata = 0.
  - i_done = d_done = 0, i_data = d_data = 0.
- Reset mid-transaction: the transaction is aborted and no done pulse is issued. Any later mem_valid is ignored while in IDLE.
- IDLE arbitration:
  - Only i_req: go to I_XFER.
  - Only d_req: go to D_XFER.
  - Both: grant the requester that is not last_grant.
  - On grant: latch address with the low OFFSET_BITS cleared, latch d_write into mem_write (0 for icache), latch d_wdata (0 for icache), and update last_grant.
- I_XFER / D_XFER:
  - mem_enable = 1 for every cycle from the cycle after the grant edge through the mem_valid cycle.
  - Address, write strobe and write data hold constant.
  - Changes on i_req/d_req/d_address during a transfer are ignored.
- Completion: in the cycle mem_valid = 1 during XFER:
  - the owner's done = 1 (combinational from mem_valid and state);
  - the owner's data output = mem_rdata in the same cycle, and the arbiter registers it so it stays stable until the next completion for that requester;
  - state returns to IDLE at the next edge and mem_enable drops.
- Writeback completion: d_done pulses; d_data is unchanged.
- Turnaround: IDLE always lasts at least one cycle. Requesters must deassert req in the cycle after done. A req still high in IDLE is treated as a new request.
- Minimum transaction length: 3 cycles (grant edge, at least one enable cycle, IDLE).
- mem_valid outside XFER: ignored, no done pulse.
- Requesters never see each other's done or data.
- No timeout; the memory is required to respond eventually.

Decomposition:
- Shared package mem_pkg:
  - constants BLOCK_WIDTH and OFFSET_BITS (also used by the caches and the memory model);
  - arbiter state encoding localparams ARB_IDLE = 2'd0, ARB_I = 2'd1, ARB_D = 2'd2;
  - GRANT_I / GRANT_D encodings.
- One small sub-module, rr_arbiter2: two requests plus last_grant in, one-hot grant out, purely combinational.
- State register, latches and output muxing stay in mem_arbiter.

Test Plan:
- Reset: hold reset = 0 for 3 cycles with i_req = d_req = 1 -> mem_enable = 0, no done pulses. Release reset -> icache granted first and mem_address = i_address & ~0xF.
- Single icache refill: i_address = 0x0000_1234, memory returns 0xDEADBEEF_..._0001 after 4 cycles -> mem_address = 0x0000_1230, mem_write = 0, i_done pulses 1 cycle, i_data = returned block, d_done stays 0.
- Dcache writeback: d_write = 1, d_address = 0x0000_2008, d_wdata = 0xA5A5... -> mem_write = 1, mem_wdata = 0xA5A5..., mem_address = 0x0000_2000, d_done pulses once, d_data unchanged.
- Contention: i_req and d_req held continuously for 4 transactions -> grants alternate I, D, I, D, with exactly one IDLE cycle between transactions.
- Mid-transaction reset: assert reset during D_XFER, then a stray mem_valid arrives in IDLE -> no d_done, mem_enable = 0.
- Input changes during a transfer: i_address changes from 0x100 to 0x200 during I_XFER -> mem_address stays 0x100 until completion.
